xor_stream_ctrl: RTL and testbench

Byte-stream XOR sequencer for the MAC encryption/decryption path. It accepts a frame of `xorLength` bytes from the data source and passes the first `xorHdrLen` bytes through unmodified. Each remaining byte is paired with one keystream byte and XORed through an `asyncXor` instance. Results are presented on a registered valid/ready output toward the TX/RX buffer logic.

---
 rtl/xor_stream_ctrl_pkg.sv | 15 +
 rtl/xor_stream_ctrl_async_xor.sv | 9 +
 rtl/xor_stream_ctrl.sv | 129 ++++++++++++
 tb/tb_xor_stream_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/xor_stream_ctrl_pkg.sv
// xorStreamPkg: shared definitions for the byte-stream XOR sequencer.
//   xor_state_e     - sequencer states (IDLE/HEADER/CIPHER/DRAIN)
//   LEN_WIDTH_DEF   - default width of frame/header length fields
//   XOR_BYPASS_KEY  - key applied to bytes that pass through unmodified
package xorStreamPkg;
  localparam int         LEN_WIDTH_DEF  = 16;
  localparam logic [7:0] XOR_BYPASS_KEY = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    CIPHER = 2'd2,
    DRAIN  = 2'd3
  } xor_state_e;
endpackage

// File: rtl/xor_stream_ctrl_async_xor.sv
// asyncXor: purely combinational byte XOR.
//   i_a - data byte, i_b - key byte, o_y - i_a ^ i_b
module asyncXor (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_y
);
  assign o_y = i_a ^ i_b;
endmodule

// File: rtl/xor_stream_ctrl.sv
// xor_stream_ctrl: accepts a frame of xorLength bytes, passes the first
// xorHdrLen bytes through, XORs the rest with one keystream byte each and
// presents results on a registered valid/ready output.
//   xorStart/xorAbort        - frame control pulses (abort wins)
//   xorLength/xorHdrLen      - lengths, sampled on an accepted start
//   dataIn/Valid/Ready       - source byte stream
//   keyIn/Valid/Ready        - keystream
//   dataOut/Valid/Ready      - registered result stream
//   xorBusy/xorDone          - frame status
module xor_stream_ctrl
  import xorStreamPkg::*;
#(
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 macCoreClk,
  input  logic                 macCoreClkHardRst_n,
  input  logic                 xorStart,
  input  logic                 xorAbort,
  input  logic [LEN_WIDTH-1:0] xorLength,
  input  logic [LEN_WIDTH-1:0] xorHdrLen,
  input  logic [7:0]           dataIn,
  input  logic                 dataInValid,
  output logic                 dataInReady,
  input  logic [7:0]           keyIn,
  input  logic                 keyInValid,
  output logic                 keyInReady,
  output logic [7:0]           dataOut,
  output logic                 dataOutValid,
  input  logic                 dataOutReady,
  output logic                 xorBusy,
  output logic                 xorDone
);

  xor_state_e           r_state, w_nxt;
  logic [LEN_WIDTH-1:0] r_cnt, r_len, r_hdr, w_cntInc;
  logic [7:0]           r_dout, w_key, w_xor;
  logic                 r_dvalid, r_done, w_doneNxt, w_accept, w_slotFree;

  assign w_slotFree   = !r_dvalid || dataOutReady;
  assign w_cntInc     = r_cnt + 1'b1;
  assign dataOut      = r_dout;
  assign dataOutValid = r_dvalid;
  assign xorDone      = r_done;
  assign xorBusy      = (r_state != IDLE);

  asyncXor u_xor (.i_a(dataIn), .i_b(w_key), .o_y(w_xor));

  always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
    if (!macCoreClkHardRst_n) r_state <= IDLE;
    else                      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    dataInReady = 1'b0;
    keyInReady  = 1'b0;
    w_accept    = 1'b0;
    w_doneNxt   = 1'b0;
    w_key       = XOR_BYPASS_KEY;
    case (r_state)
      IDLE: begin
        if (xorStart)
          w_nxt = (xorLength == '0) ? DRAIN : ((xorHdrLen != '0) ? HEADER : CIPHER);
      end
      HEADER: begin
        dataInReady = w_slotFree;
        w_accept    = dataInValid && w_slotFree;
        // Length check first so hdr >= len bypasses the whole frame.
        if (w_accept) begin
          if (w_cntInc == r_len)      w_nxt = DRAIN;
          else if (w_cntInc == r_hdr) w_nxt = CIPHER;
        end
      end
      CIPHER: begin
        w_key       = keyIn;
        // Cross-coupled readies: data and key only ever move as a pair.
        dataInReady = keyInValid && w_slotFree;
        keyInReady  = dataInValid && w_slotFree;
        w_accept    = dataInValid && keyInValid && w_slotFree;
        if (w_accept && (w_cntInc == r_len)) w_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_slotFree) begin
          w_doneNxt = 1'b1;
          w_nxt     = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
    // Abort drops readies too, so no source sees a handshake that gets discarded.
    if (xorAbort) begin
      w_nxt       = IDLE;
      dataInReady = 1'b0;
      keyInReady  = 1'b0;
      w_accept    = 1'b0;
      w_doneNxt   = 1'b0;
    end
  end

  always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
    if (!macCoreClkHardRst_n) begin
      r_cnt    <= '0;
      r_len    <= '0;
      r_hdr    <= '0;
      r_dout   <= 8'h00;
      r_dvalid <= 1'b0;
      r_done   <= 1'b0;
    end else if (xorAbort) begin
      r_cnt    <= '0;
      r_dvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_doneNxt;
      if ((r_state == IDLE) && xorStart) begin
        r_len <= xorLength;
        r_hdr <= xorHdrLen;
        r_cnt <= '0;
      end
      if (w_accept) begin
        r_cnt    <= w_cntInc;
        r_dout   <= w_xor;
        r_dvalid <= 1'b1;
      end else if (dataOutReady) begin
        r_dvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xor_stream_ctrl.sv
module tb_xor_stream_ctrl;
  logic        macCoreClk, macCoreClkHardRst_n;
  logic        xorStart, xorAbort;
  logic [15:0] xorLength, xorHdrLen;
  logic [7:0]  dataIn, keyIn, dataOut;
  logic        dataInValid, dataInReady, keyInValid, keyInReady;
  logic        dataOutValid, dataOutReady, xorBusy, xorDone;

  int errs = 0, checks = 0;
  byte unsigned dq[64], kq[64];

  xor_stream_ctrl #(.LEN_WIDTH(16)) dut (
    .macCoreClk(macCoreClk), .macCoreClkHardRst_n(macCoreClkHardRst_n),
    .xorStart(xorStart), .xorAbort(xorAbort),
    .xorLength(xorLength), .xorHdrLen(xorHdrLen),
    .dataIn(dataIn), .dataInValid(dataInValid), .dataInReady(dataInReady),
    .keyIn(keyIn), .keyInValid(keyInValid), .keyInReady(keyInReady),
    .dataOut(dataOut), .dataOutValid(dataOutValid), .dataOutReady(dataOutReady),
    .xorBusy(xorBusy), .xorDone(xorDone)
  );

  initial macCoreClk = 1'b0;
  always #5 macCoreClk = ~macCoreClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      dq[i] = 8'($urandom);
      kq[i] = 8'($urandom);
    end
  endtask

  task automatic idle_inputs();
    xorStart = 0; xorAbort = 0; dataInValid = 0; keyInValid = 0;
    dataOutReady = 0; dataIn = 0; keyIn = 0;
  endtask

  // Reference: byte i of the frame is data[i] XOR (i < hdr ? 0 : key[i-hdr]).
  // pin/pkey/pout are valid/ready probabilities in percent;
  // pkey<0 -> key offered every 3rd cycle, pout<0 -> sink stalls 5 cycles.
  task automatic run_frame(input int len, input int hdr, input int pin, input int pkey,
                           input int pout, input bit restart, input int abort_at,
                           input int expcyc);
    byte unsigned eq[$];
    byte unsigned prev_out = 0;
    int  di = 0, ki = 0, oi = 0, j = 0, nkey = 0;
    int  nk = (len > hdr) ? len - hdr : 0;
    bit  dv = 0, kv = 0, done_seen = 0, last_prev = 0, hold_prev = 0;
    bit  din_hs, key_hs, out_hs, exp_done;
    eq = {};
    for (int i = 0; i < len; i++)
      eq.push_back(dq[i] ^ ((i < hdr) ? 8'h00 : kq[i - hdr]));
    @(posedge macCoreClk); #1;
    xorLength = 16'(len); xorHdrLen = 16'(hdr); xorStart = 1;
    while (!done_seen && j < 3000) begin
      @(posedge macCoreClk); #1;
      j++;
      xorStart = restart && (j == 3);
      if (xorStart) begin xorLength = 16'd2; xorHdrLen = 16'd0; end
      if (abort_at >= 0 && di == abort_at) begin
        xorAbort = 1; dataInValid = 0; keyInValid = 0; dataOutReady = 0;
        @(negedge macCoreClk);
        chk("abort_rdy", {dataInReady, keyInReady}, 2'b00);
        @(posedge macCoreClk); #1;
        xorAbort = 0;
        @(negedge macCoreClk);
        chk("abort_busy", xorBusy, 0);
        chk("abort_dvalid", dataOutValid, 0);
        chk("abort_done", xorDone, 0);
        repeat (3) begin
          @(negedge macCoreClk);
          chk("abort_nodone", xorDone, 0);
        end
        idle_inputs();
        return;
      end
      if (!dv) dv = (di < len) && ($urandom_range(99) < pin);
      if (!kv) kv = (ki < nk) && ((pkey < 0) ? (j % 3 == 0) : ($urandom_range(99) < pkey));
      dataInValid = dv; dataIn = dv ? dq[di] : 8'($urandom);
      keyInValid  = kv; keyIn  = kv ? kq[ki] : 8'($urandom);
      dataOutReady = (pout < 0) ? !(j >= 2 && j <= 6) : ($urandom_range(99) < pout);
      @(negedge macCoreClk);
      exp_done = last_prev || (len == 0 && j == 2);
      chk("done", xorDone, exp_done);
      chk("busy", xorBusy, !exp_done);
      if (xorDone) done_seen = 1;
      if (hold_prev) begin
        chk("hold_valid", dataOutValid, 1);
        chk("hold_data", dataOut, prev_out);
      end
      if (dataOutValid && !dataOutReady)
        chk("full_rdy", {dataInReady, keyInReady}, 2'b00);
      din_hs = dataInValid && dataInReady;
      key_hs = keyInValid && keyInReady;
      chk("pairing", key_hs, din_hs && (di >= hdr));
      out_hs = dataOutValid && dataOutReady;
      if (out_hs) begin
        chk("out_data", dataOut, (oi < len) ? eq[oi] : 9'h100);
        oi++;
      end
      if (din_hs) begin di++; dv = 0; end
      if (key_hs) begin ki++; kv = 0; nkey++; end
      last_prev = out_hs && (oi == len);
      hold_prev = dataOutValid && !dataOutReady;
      prev_out  = dataOut;
    end
    chk("finished", done_seen, 1);
    chk("out_count", oi, len);
    chk("key_count", nkey, nk);
    if (expcyc >= 0) chk("cycles", j, expcyc);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    xorLength = 0; xorHdrLen = 0;
    macCoreClkHardRst_n = 0;
    repeat (2) @(posedge macCoreClk);
    #1;
    chk("rst_out", {dataInReady, keyInReady, dataOutValid, xorBusy, xorDone}, 5'b0);
    chk("rst_data", dataOut, 8'h00);
    @(negedge macCoreClk); macCoreClkHardRst_n = 1;

    // Directed: len 4, hdr 0, sink always ready.
    dq[0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
    kq[0:3] = '{8'hFF, 8'h0F, 8'hF0, 8'hAA};
    run_frame(4, 0, 100, 100, 100, 0, -1, 6);

    // Directed: len 6, hdr 2, constant key 80.
    for (int i = 0; i < 6; i++) begin dq[i] = 8'(i + 1); kq[i] = 8'h80; end
    run_frame(6, 2, 100, 100, 100, 0, -1, 8);

    // Sink stall of 5 cycles after the first byte.
    fill_random();
    run_frame(3, 0, 100, 100, -1, 0, -1, 10);

    // Keystream gaps of 2 cycles.
    fill_random();
    run_frame(6, 1, 100, -1, 100, 0, -1, -1);

    // Empty frame, then start while busy on an 8-byte frame.
    run_frame(0, 0, 100, 100, 100, 0, -1, 2);
    fill_random();
    run_frame(8, 0, 100, 100, 100, 1, -1, 10);

    // Header covers the whole frame: no keystream used.
    fill_random();
    run_frame(5, 9, 100, 100, 100, 0, -1, 7);

    // Abort after 2 of 5, then a normal 1-byte frame.
    fill_random();
    run_frame(5, 0, 100, 100, 100, 0, 2, -1);
    fill_random();
    run_frame(1, 0, 100, 100, 100, 0, -1, 3);

    // Random frames with random source/sink pacing.
    for (int t = 0; t < 12; t++) begin
      int l, h;
      fill_random();
      l = $urandom_range(1, 40);
      h = $urandom_range(0, l + 2);
      run_frame(l, h, $urandom_range(30, 100), $urandom_range(30, 100),
                $urandom_range(30, 100), 0, -1, -1);
    end

    // Asynchronous reset mid-frame.
    fill_random();
    @(posedge macCoreClk); #1;
    xorLength = 16'd8; xorHdrLen = 16'd8; xorStart = 1;
    @(posedge macCoreClk); #1;
    xorStart = 0; dataInValid = 1; dataIn = 8'h5A; dataOutReady = 0;
    repeat (2) @(posedge macCoreClk);
    #2;
    chk("pre_rst_busy", {xorBusy, dataOutValid}, 2'b11);
    macCoreClkHardRst_n = 0;
    #1;
    chk("arst_out", {dataInReady, keyInReady, dataOutValid, xorBusy, xorDone}, 5'b0);
    chk("arst_data", dataOut, 8'h00);
    idle_inputs();
    @(negedge macCoreClk); macCoreClkHardRst_n = 1;
    fill_random();
    run_frame(3, 1, 100, 100, 100, 0, -1, 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
